acc_exec_sequencer: RTL and testbench
=====================================

// Module: acc_exec_sequencer
// PURPOSE
//   Upstream operand/accumulator stage for the ALU. Holds the 16-bit accumulator (ACC) and a
//   latched operand (Q), and sequences one ALU operation per start request: issue, enable, write-back.
//   Drives the ALU's P/Q/op/en inputs and its C9/C10 bus strobes. Captures BR into ACC and MR into MRH.
// PARAMETERS
//   DW        16   datapath width; ACC, Q, BR, MR and MRH are all DW bits wide
// PORTS
//   i_clk          in   1    clock, rising edge
//   i_rst_n        in   1    reset, asynchronous, active-low
//   i_start        in   1    request one ALU operation; sampled only in IDLE
//   i_op           in   3    ALU op code (000 ADD .. 111 SHIFTL; 010 = MPY); latched at start
//   i_mbr          in   DW   operand from memory buffer; becomes Q at start, or ACC on load
//   i_load_acc     in   1    ACC <= i_mbr; honoured in IDLE only
//   i_clear_acc    in   1    ACC <= 0 and MRH <= 0; honoured in IDLE only
//   i_br           in   DW   ALU BR bus (valid while o_c9=1)
//   i_mr           in   DW   ALU MR bus (valid while o_c10=1)
//   o_acc_alu_p    out  DW   ALU operand P = ACC (registered)
//   o_acc_alu_q    out  DW   ALU operand Q = latched operand (registered)
//   o_alu_op       out  3    latched op code
//   o_alu_en       out  1    ALU enable; high exactly one cycle (EXEC)
//   o_c9           out  1    BR read strobe (WB)
//   o_c10          out  1    MR read strobe (WBH, MPY only)
//   o_acc          out  DW   current ACC value
//   o_mrh          out  DW   last captured MPY high half
//   o_busy         out  1    high in every state except IDLE
//   o_done         out  1    one-cycle completion pulse (DONE)
// BEHAVIOUR
//   Reset: state=IDLE; ACC, Q, MRH, op = 0; all outputs 0. Reset mid-operation aborts at once:
//     strobes drop asynchronously, and ACC keeps no partial result.
//   FSM: IDLE -> EXEC -> WB -> [WBH] -> DONE -> IDLE. Every non-IDLE state lasts exactly 1 cycle.
//   IDLE:  Priority is i_clear_acc > i_load_acc > i_start.
//     A clear or load consumes the cycle, and i_start in that same cycle is dropped (no busy).
//     On i_start: Q <= i_mbr, op <= i_op, next EXEC.
//   EXEC:  o_alu_en=1, o_alu_op=op; P=ACC, Q stable. The ALU registers BR/MR at the end of this cycle.
//   WB:    o_c9=1. At the clock edge ACC <= i_br. Next state is WBH if op==010, else DONE.
//   WBH:   o_c10=1. At the clock edge MRH <= i_mr. Next DONE.
//   DONE:  o_done=1, o_busy=1. Next IDLE. A new i_start is accepted from the following cycle.
//   Latency, with start sampled at edge k: en high in cycle k+1; done high in cycle k+3 (non-MPY)
//     or k+4 (MPY). Back-to-back throughput: 1 op per 4 (5 for MPY) cycles.
//   o_c9 and o_c10 are never high in the same cycle. Neither is ever high together with o_alu_en.
//   i_start, i_op, i_mbr, i_load_acc and i_clear_acc are ignored while busy.
//     Q and op stay frozen for the whole operation.
//   No arithmetic in this block. ACC takes BR verbatim, including wrap-around results.
//     MRH is updated only by MPY; other ops leave it unchanged.
//   NOT (101) still drives P=ACC; the ALU ignores it. ACC <= ~Q via BR.
// TESTING
//   1. Assert reset for 3 cycles -> all outputs 0, o_busy=0.
//      Release reset -> stays IDLE with no strobes.
//   2. load ACC=0x0005; start ADD with i_mbr=0x0003; ALU model BR=0x0008 ->
//      en in cycle 1, c9 in cycle 2, done in cycle 3, o_acc=0x0008, o_c10 never high.
//   3. ACC=0x0100; start MPY with Q=0x0100; model BR=0x0000, MR=0x0001 ->
//      c9 then c10 on consecutive cycles, o_acc=0x0000, o_mrh=0x0001, done in cycle 4.
//   4. During an ADD, toggle i_start, i_op=111, i_mbr=0xFFFF and i_load_acc each cycle ->
//      o_alu_op and o_acc_alu_q unchanged, exactly one done, ACC = BR.
//   5. Assert i_rst_n low while o_c9=1 -> o_c9 and o_busy drop immediately, ACC=0.
//      Release reset -> a new op works normally.
//   6. In IDLE, raise i_load_acc(i_mbr=0x1234) and i_start together -> ACC=0x1234, o_busy stays 0.
//      Then i_clear_acc together with i_load_acc -> ACC=0, MRH=0.

Source files
------------

// File: rtl/acc_exec_sequencer_if.sv
// ----------------------------------------------------------------------------
// acc_exec_sequencer_if
//   Bundles the request side and the ALU side of the accumulator/operand
//   sequencer into one interface.
//   master : the controller/bench that issues requests and models the ALU buses
//   slave  : the acc_exec_sequencer itself
// Signals
//   i_start, i_op, i_mbr, i_load_acc, i_clear_acc : operation / ACC requests
//   i_br, i_mr                                    : ALU result buses
//   o_acc_alu_p, o_acc_alu_q, o_alu_op, o_alu_en  : ALU operand/control drive
//   o_c9, o_c10                                   : BR / MR read strobes
//   o_acc, o_mrh, o_busy, o_done                  : status
// ----------------------------------------------------------------------------
interface acc_exec_sequencer_if #(
  parameter int DW = 16
);
  logic          i_start;
  logic [2:0]    i_op;
  logic [DW-1:0] i_mbr;
  logic          i_load_acc;
  logic          i_clear_acc;
  logic [DW-1:0] i_br;
  logic [DW-1:0] i_mr;
  logic [DW-1:0] o_acc_alu_p;
  logic [DW-1:0] o_acc_alu_q;
  logic [2:0]    o_alu_op;
  logic          o_alu_en;
  logic          o_c9;
  logic          o_c10;
  logic [DW-1:0] o_acc;
  logic [DW-1:0] o_mrh;
  logic          o_busy;
  logic          o_done;

  modport master (
    output i_start, i_op, i_mbr, i_load_acc, i_clear_acc, i_br, i_mr,
    input  o_acc_alu_p, o_acc_alu_q, o_alu_op, o_alu_en, o_c9, o_c10,
           o_acc, o_mrh, o_busy, o_done
  );

  modport slave (
    input  i_start, i_op, i_mbr, i_load_acc, i_clear_acc, i_br, i_mr,
    output o_acc_alu_p, o_acc_alu_q, o_alu_op, o_alu_en, o_c9, o_c10,
           o_acc, o_mrh, o_busy, o_done
  );
endinterface

// File: rtl/acc_exec_sequencer.sv
// ----------------------------------------------------------------------------
// acc_exec_sequencer
//   Operand/accumulator stage in front of the ALU. Holds ACC and the latched
//   operand Q, and runs one ALU operation per start request:
//   IDLE -> EXEC -> WB -> [WBH, MPY only] -> DONE -> IDLE.
//   EXEC pulses the ALU enable, WB strobes C9 and copies BR into ACC, WBH
//   strobes C10 and copies MR into MRH. No arithmetic is done here.
// Ports
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset (aborts any operation at once)
//   bus     : acc_exec_sequencer_if.slave (requests, ALU buses, status)
// ----------------------------------------------------------------------------
module acc_exec_sequencer #(
  parameter int DW = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  acc_exec_sequencer_if.slave   bus
);

  localparam logic [2:0] OP_MPY = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
    S_WB   = 3'd2,
    S_WBH  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [DW-1:0] acc;
  logic [DW-1:0] q;
  logic [DW-1:0] mrh;
  logic [2:0]    op;

  logic          alu_en;
  logic          c9;
  logic          c10;
  logic          busy;
  logic          done;

  // A clear or load owns the IDLE cycle; a start raised with it is dropped.
  logic          start_ok;
  assign start_ok = bus.i_start && !bus.i_clear_acc && !bus.i_load_acc;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = start_ok ? S_EXEC : S_IDLE;
      S_EXEC:  state_nxt = S_WB;
      S_WB:    state_nxt = (op == OP_MPY) ? S_WBH : S_DONE;
      S_WBH:   state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode: strobes come straight from the state register so an
  // asynchronous reset removes them immediately.
  always_comb begin
    alu_en = 1'b0;
    c9     = 1'b0;
    c10    = 1'b0;
    done   = 1'b0;
    busy   = 1'b1;
    case (state)
      S_IDLE:  busy   = 1'b0;
      S_EXEC:  alu_en = 1'b1;
      S_WB:    c9     = 1'b1;
      S_WBH:   c10    = 1'b1;
      S_DONE:  done   = 1'b1;
      default: busy   = 1'b0;
    endcase
  end

  // ACC / Q / op / MRH registers. Requests are only looked at in IDLE, so
  // Q and op stay frozen for the whole operation.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc <= '0;
      q   <= '0;
      mrh <= '0;
      op  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.i_clear_acc) begin
            acc <= '0;
            mrh <= '0;
          end else if (bus.i_load_acc) begin
            acc <= bus.i_mbr;
          end else if (bus.i_start) begin
            q  <= bus.i_mbr;
            op <= bus.i_op;
          end
        end
        S_WB:    acc <= bus.i_br;
        S_WBH:   mrh <= bus.i_mr;
        default: ;
      endcase
    end
  end

  assign bus.o_acc_alu_p = acc;
  assign bus.o_acc_alu_q = q;
  assign bus.o_alu_op    = op;
  assign bus.o_alu_en    = alu_en;
  assign bus.o_c9        = c9;
  assign bus.o_c10       = c10;
  assign bus.o_acc       = acc;
  assign bus.o_mrh       = mrh;
  assign bus.o_busy      = busy;
  assign bus.o_done      = done;

endmodule

// File: tb/tb_acc_exec_sequencer.sv
// ----------------------------------------------------------------------------
// tb_acc_exec_sequencer
//   Randomized scoreboard bench. The driver keeps a behavioural ACC/MRH model
//   plus a small ALU model, pushes one expected record per accepted start, and
//   a negedge monitor pops and compares when the DUT pulses en / done.
// ----------------------------------------------------------------------------
module tb_acc_exec_sequencer;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  acc_exec_sequencer_if #(.DW(DW)) bus ();

  acc_exec_sequencer #(.DW(DW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  typedef struct {
    logic [2:0]    op;
    logic [DW-1:0] p;
    logic [DW-1:0] q;
    logic [DW-1:0] br;
    logic [DW-1:0] mr;
    logic [DW-1:0] acc_exp;
    logic [DW-1:0] mrh_exp;
    bit            mpy;
    int            start_cyc;
  } txn_t;

  txn_t          sb[$];
  int            checks = 0;
  int            passed = 0;
  int            cyc = 0;
  logic [DW-1:0] m_acc = '0;
  logic [DW-1:0] m_mrh = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference ALU: the result buses the real ALU would present for (op, P, Q).
  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [DW-1:0] p,
                                          input logic [DW-1:0] q);
    logic [31:0]   prod;
    logic [DW-1:0] br;
    logic [DW-1:0] mr;
    mr   = DW'($urandom);
    prod = 32'(p) * 32'(q);
    case (op)
      3'd0:    br = p + q;
      3'd1:    br = p - q;
      3'd2:    begin br = prod[15:0]; mr = prod[31:16]; end
      3'd3:    br = p & q;
      3'd4:    br = p | q;
      3'd5:    br = ~q;
      3'd6:    br = p >> 1;
      default: br = p << 1;
    endcase
    return {mr, br};
  endfunction

  // ---------------- monitor ----------------
  txn_t mt;
  int   c9n = 0;
  int   c10n = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("strobe_excl", {31'b0, (bus.o_c9 & bus.o_c10) | (bus.o_alu_en & (bus.o_c9 | bus.o_c10))}, 32'd0);
      if (bus.o_alu_en) begin
        c9n  = 0;
        c10n = 0;
        if (sb.size() == 0) chk("en_unexpected", 32'd1, 32'd0);
        else begin
          mt = sb[0];
          chk("en_op", 32'(bus.o_alu_op), 32'(mt.op));
          chk("en_q", 32'(bus.o_acc_alu_q), 32'(mt.q));
          chk("en_p", 32'(bus.o_acc_alu_p), 32'(mt.p));
          chk("en_latency", 32'(cyc - mt.start_cyc), 32'd0);
        end
      end
      if (bus.o_c9) c9n++;
      if (bus.o_c10) c10n++;
      if (bus.o_done) begin
        if (sb.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
        else begin
          mt = sb.pop_front();
          chk("done_acc", 32'(bus.o_acc), 32'(mt.acc_exp));
          chk("done_mrh", 32'(bus.o_mrh), 32'(mt.mrh_exp));
          chk("done_q_frozen", 32'(bus.o_acc_alu_q), 32'(mt.q));
          chk("done_op_frozen", 32'(bus.o_alu_op), 32'(mt.op));
          chk("done_busy", 32'(bus.o_busy), 32'd1);
          chk("done_latency", 32'(cyc - mt.start_cyc), mt.mpy ? 32'd3 : 32'd2);
          chk("c9_count", 32'(c9n), 32'd1);
          chk("c10_count", 32'(c10n), mt.mpy ? 32'd1 : 32'd0);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    bus.i_start     = 1'b0;
    bus.i_op        = 3'd0;
    bus.i_mbr       = '0;
    bus.i_load_acc  = 1'b0;
    bus.i_clear_acc = 1'b0;
    bus.i_br        = DW'($urandom);
    bus.i_mr        = DW'($urandom);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [DW-1:0] mbr, input bit noise,
                        input bit abort);
    logic [31:0] res;
    txn_t        t;
    bit          seen_done;
    seen_done       = 1'b0;
    res             = alu_ref(op, m_acc, mbr);
    bus.i_start     = 1'b1;
    bus.i_op        = op;
    bus.i_mbr       = mbr;
    bus.i_load_acc  = 1'b0;
    bus.i_clear_acc = 1'b0;
    step();
    t.op        = op;
    t.p         = m_acc;
    t.q         = mbr;
    t.br        = res[DW-1:0];
    t.mr        = res[31:16];
    t.mpy       = (op == 3'b010);
    t.start_cyc = cyc;
    m_acc       = t.br;
    if (t.mpy) m_mrh = t.mr;
    t.acc_exp   = m_acc;
    t.mrh_exp   = m_mrh;
    sb.push_back(t);
    for (int i = 0; i < 8; i++) begin
      if (noise) begin
        bus.i_start     = 1'($urandom);
        bus.i_op        = 3'($urandom);
        bus.i_mbr       = DW'($urandom);
        bus.i_load_acc  = 1'($urandom);
        bus.i_clear_acc = 1'($urandom);
      end else begin
        bus.i_start = 1'b0;
      end
      bus.i_br = bus.o_c9  ? t.br : DW'($urandom);
      bus.i_mr = bus.o_c10 ? t.mr : DW'($urandom);
      if (abort && bus.o_c9) begin
        rst_n = 1'b0;
        #1;
        chk("abort_c9", 32'(bus.o_c9), 32'd0);
        chk("abort_busy", 32'(bus.o_busy), 32'd0);
        chk("abort_acc", 32'(bus.o_acc), 32'd0);
        chk("abort_mrh", 32'(bus.o_mrh), 32'd0);
        sb.delete();
        m_acc = '0;
        m_mrh = '0;
        idle_inputs();
        step();
        rst_n = 1'b1;
        step();
        return;
      end
      if (bus.o_done) begin
        seen_done = 1'b1;
        idle_inputs();
        step();
        break;
      end
      step();
    end
    if (!seen_done) chk("op_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_load(input logic [DW-1:0] v, input bit with_start);
    bus.i_load_acc  = 1'b1;
    bus.i_clear_acc = 1'b0;
    bus.i_mbr       = v;
    bus.i_start     = with_start;
    bus.i_op        = 3'($urandom);
    step();
    idle_inputs();
    m_acc = v;
    chk("load_acc", 32'(bus.o_acc), 32'(m_acc));
    chk("load_busy", 32'(bus.o_busy), 32'd0);
    chk("load_no_en", 32'(bus.o_alu_en), 32'd0);
  endtask

  task automatic do_clear();
    bus.i_clear_acc = 1'b1;
    bus.i_load_acc  = 1'($urandom);
    bus.i_start     = 1'($urandom);
    bus.i_mbr       = DW'($urandom);
    step();
    idle_inputs();
    m_acc = '0;
    m_mrh = '0;
    chk("clear_acc", 32'(bus.o_acc), 32'd0);
    chk("clear_mrh", 32'(bus.o_mrh), 32'd0);
    chk("clear_busy", 32'(bus.o_busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #2;
    chk("rst_acc", 32'(bus.o_acc), 32'd0);
    chk("rst_mrh", 32'(bus.o_mrh), 32'd0);
    chk("rst_p", 32'(bus.o_acc_alu_p), 32'd0);
    chk("rst_q", 32'(bus.o_acc_alu_q), 32'd0);
    chk("rst_op", 32'(bus.o_alu_op), 32'd0);
    chk("rst_ctl", {28'b0, bus.o_alu_en, bus.o_c9, bus.o_c10, bus.o_done}, 32'd0);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    rst_n = 1'b1;
    step();
    step();
    chk("idle_ctl", {28'b0, bus.o_alu_en, bus.o_c9, bus.o_c10, bus.o_done}, 32'd0);
    chk("idle_busy", 32'(bus.o_busy), 32'd0);

    do_load(16'h0005, 1'b0);
    run_op(3'b000, 16'h0003, 1'b0, 1'b0);
    chk("add_acc", 32'(bus.o_acc), 32'h0008);

    do_load(16'h0100, 1'b0);
    run_op(3'b010, 16'h0100, 1'b0, 1'b0);
    chk("mpy_acc", 32'(bus.o_acc), 32'h0000);
    chk("mpy_mrh", 32'(bus.o_mrh), 32'h0001);

    run_op(3'b000, DW'($urandom), 1'b1, 1'b0);

    run_op(3'b000, DW'($urandom), 1'b0, 1'b1);
    run_op(3'b001, DW'($urandom), 1'b0, 1'b0);

    do_load(16'h1234, 1'b1);
    chk("load_start_busy", 32'(bus.o_busy), 32'd0);
    do_clear();

    repeat (60) begin
      case ($urandom_range(0, 5))
        0:       do_load(DW'($urandom), 1'($urandom));
        1:       do_clear();
        2:       run_op(3'($urandom), DW'($urandom), 1'($urandom), 1'b1);
        default: run_op(3'($urandom), DW'($urandom), 1'($urandom), 1'b0);
      endcase
      chk("model_acc", 32'(bus.o_acc), 32'(m_acc));
    end

    step();
    step();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
